// File: rtl/hazard_scoreboard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
//   Shared types, constants and width helpers for the hazard/scoreboard unit
//   that sits between decode and execute.
//   Contents:
//     fwd_sel_w()    width of a forwarding select for a given stage count
//     cnt_w_for()    width of a counter that must hold 0..max_val
//     OPC_LOAD/STORE major opcodes of the memory instructions
//     stall_cause_t  individual stall terms, ORed into the stall output
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_NUM_FWD   = 2;
  localparam int DEF_MAX_OUTST = 4;
  localparam int DEF_CNT_W     = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // A select of 0 means "register file", k means stage k-1, so the encoding
  // needs NUM_FWD+1 distinct values.
  function automatic int fwd_sel_w(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

  function automatic int cnt_w_for(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  typedef logic [fwd_sel_w(DEF_NUM_FWD)-1:0] fwd_sel_t;

  typedef struct packed {
    logic load_use;  // youngest producer of a source is not ready yet
    logic raw;       // source is pending on a long-latency op
    logic waw;       // destination is pending on a long-latency op
    logic cap;       // no free slot for another long-latency op
  } stall_cause_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit_if
//   Bundles every decode/execute/stage/long-unit signal seen by the hazard
//   unit plus its forwarding, stall and scoreboard outputs.
//   Modports:
//     master  pipeline side: drives stage information, receives decisions
//     slave   hazard unit:   reads stage information, drives decisions
// ---------------------------------------------------------------------------
interface hazard_scoreboard_unit_if #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_FWD   = 2,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 32
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  // decode stage
  logic [ADDR_W-1:0]         id_rs1;
  logic [ADDR_W-1:0]         id_rs2;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [ADDR_W-1:0]         id_rd;
  logic                      id_we;
  logic                      id_long;
  logic                      id_valid;
  // execute stage
  logic [ADDR_W-1:0]         ex_rs1;
  logic [ADDR_W-1:0]         ex_rs2;
  logic                      ex_rs1_used;
  logic                      ex_rs2_used;
  logic                      ex_is_store;
  // forwarding source stages, index 0 youngest
  logic [NUM_FWD*ADDR_W-1:0] stg_rd;
  logic [NUM_FWD-1:0]        stg_we;
  logic [NUM_FWD-1:0]        stg_rdy;
  // long-latency unit writeback and branch flush
  logic                      lu_wb_valid;
  logic [ADDR_W-1:0]         lu_wb_rd;
  logic                      flush;
  // decisions
  logic [SEL_W-1:0]          fwd_a;
  logic [SEL_W-1:0]          fwd_b;
  logic [SEL_W-1:0]          fwd_st;
  logic                      stall;
  logic [NUM_REGS-1:0]       pending;
  logic [OUT_W-1:0]          outst_cnt;
  logic [CNT_W-1:0]          stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_long,
           id_valid, ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_is_store,
           stg_rd, stg_we, stg_rdy, lu_wb_valid, lu_wb_rd, flush,
    input  fwd_a, fwd_b, fwd_st, stall, pending, outst_cnt, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_long,
           id_valid, ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_is_store,
           stg_rd, stg_we, stg_rdy, lu_wb_valid, lu_wb_rd, flush,
    output fwd_a, fwd_b, fwd_st, stall, pending, outst_cnt, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
//   Youngest-first priority encoder choosing the forwarding source for one
//   execute-stage operand.
//   Ports:
//     src_i      operand register address
//     used_i     operand is actually read
//     stg_rd_i   packed destination per stage, stage 0 in the low bits
//     stg_we_i   stage writes its destination
//     stg_rdy_i  stage result is available
//     sel_o      0 = register file, k = stage k-1
// ---------------------------------------------------------------------------
module fwd_select import hazard_pkg::*; #(
  parameter int NUM_FWD = 2,
  parameter int ADDR_W  = 5,
  parameter int SEL_W   = fwd_sel_w(NUM_FWD)
) (
  input  logic [ADDR_W-1:0]         src_i,
  input  logic                      used_i,
  input  logic [NUM_FWD*ADDR_W-1:0] stg_rd_i,
  input  logic [NUM_FWD-1:0]        stg_we_i,
  input  logic [NUM_FWD-1:0]        stg_rdy_i,
  output logic [SEL_W-1:0]          sel_o
);

  logic found;

  // NOTE: every variable written in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_o = '0;
    found = 1'b0;
    for (int s = 0; s < NUM_FWD; s++) begin
      if (!found && used_i && stg_we_i[s] &&
          (stg_rd_i[s*ADDR_W +: ADDR_W] != '0) &&
          (stg_rd_i[s*ADDR_W +: ADDR_W] == src_i)) begin
        // The youngest match owns the operand even when it is not ready:
        // older stages hold a stale value and the load-use stall covers it.
        found = 1'b1;
        if (stg_rdy_i[s]) begin
          sel_o = SEL_W'(s + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_unit
//   Operand forwarding, load-use stall detection and a scoreboard for
//   long-latency (mul/div) results, placed between decode and execute.
//   Forwarding selects and stall are combinational; the pending vector, the
//   outstanding-op count and the stall-cycle counter are registered.
//   Ports:
//     CLK  clock
//     RST  asynchronous active-high reset
//     bus  hazard_scoreboard_unit_if.slave: decode/execute/stage inputs,
//          fwd_a/fwd_b/fwd_st, stall, pending, outst_cnt, stall_cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard_unit import hazard_pkg::*; #(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_FWD   = DEF_NUM_FWD,
  parameter int MAX_OUTST = DEF_MAX_OUTST,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int SEL_W = fwd_sel_w(NUM_FWD);
  localparam int OUT_W = cnt_w_for(MAX_OUTST);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  stall_cause_t cause;
  logic         seen_rs1, seen_rs2;
  logic         stall;
  logic         issue;
  logic         wb_clr;

  // ---------------------------------------------------------------- forwarding
  fwd_select #(.NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_fwd_a (
    .src_i    (bus.ex_rs1),
    .used_i   (bus.ex_rs1_used),
    .stg_rd_i (bus.stg_rd),
    .stg_we_i (bus.stg_we),
    .stg_rdy_i(bus.stg_rdy),
    .sel_o    (bus.fwd_a)
  );

  fwd_select #(.NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_fwd_b (
    .src_i    (bus.ex_rs2),
    .used_i   (bus.ex_rs2_used),
    .stg_rd_i (bus.stg_rd),
    .stg_we_i (bus.stg_we),
    .stg_rdy_i(bus.stg_rdy),
    .sel_o    (bus.fwd_b)
  );

  // Store data always comes through rs2, whether or not the ALU reads it.
  fwd_select #(.NUM_FWD(NUM_FWD), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) u_fwd_st (
    .src_i    (bus.ex_rs2),
    .used_i   (bus.ex_is_store),
    .stg_rd_i (bus.stg_rd),
    .stg_we_i (bus.stg_we),
    .stg_rdy_i(bus.stg_rdy),
    .sel_o    (bus.fwd_st)
  );

  // -------------------------------------------------------------- stall terms
  always_comb begin
    cause    = '0;
    seen_rs1 = 1'b0;
    seen_rs2 = 1'b0;
    // Load-use: each decode source looks at its own youngest producer and
    // stalls when that producer has not produced its value yet.
    for (int s = 0; s < NUM_FWD; s++) begin
      if (!seen_rs1 && bus.id_rs1_used && bus.stg_we[s] &&
          (bus.stg_rd[s*ADDR_W +: ADDR_W] != '0) &&
          (bus.stg_rd[s*ADDR_W +: ADDR_W] == bus.id_rs1)) begin
        seen_rs1 = 1'b1;
        if (!bus.stg_rdy[s]) cause.load_use = 1'b1;
      end
      if (!seen_rs2 && bus.id_rs2_used && bus.stg_we[s] &&
          (bus.stg_rd[s*ADDR_W +: ADDR_W] != '0) &&
          (bus.stg_rd[s*ADDR_W +: ADDR_W] == bus.id_rs2)) begin
        seen_rs2 = 1'b1;
        if (!bus.stg_rdy[s]) cause.load_use = 1'b1;
      end
    end
    cause.raw = bus.id_valid &&
                ((bus.id_rs1_used && pending_q[bus.id_rs1]) ||
                 (bus.id_rs2_used && pending_q[bus.id_rs2]));
    cause.waw = bus.id_valid && bus.id_we && pending_q[bus.id_rd];
    cause.cap = bus.id_valid && bus.id_long && (outst_q == OUT_W'(MAX_OUTST));
  end

  // Held low through reset so nothing upstream freezes on reset-time inputs.
  assign stall = !RST && (|cause);

  // ------------------------------------------------------------- scoreboard
  assign issue = bus.id_valid && bus.id_long && bus.id_we &&
                 (bus.id_rd != '0) && !stall && !bus.flush;

  // A writeback only counts when its register is actually outstanding; this
  // keeps stray writebacks from underflowing outst_cnt.
  assign wb_clr = bus.lu_wb_valid && (bus.lu_wb_rd != '0) &&
                  pending_q[bus.lu_wb_rd];

  always_comb begin
    pending_d = pending_q;
    if (wb_clr) pending_d[bus.lu_wb_rd] = 1'b0;
    // Applied after the clear so a same-register issue wins.
    if (issue)  pending_d[bus.id_rd]    = 1'b1;
    pending_d[0] = 1'b0;

    outst_d = outst_q;
    case ({issue, wb_clr})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   if (outst_q != '0) outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering. The pending vector is
  // plain flops, so it is cleared by reset like any other state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q   <= '0;
      outst_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      outst_q     <= outst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.pending      = pending_q;
  assign bus.outst_cnt    = outst_q;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard_unit
//   Directed bench for hazard_scoreboard_unit. Inputs change just after the
//   falling edge; outputs are sampled 1 time unit later, well before the
//   next rising edge.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard_unit;

  localparam int NUM_REGS  = 32;
  localparam int ADDR_W    = 5;
  localparam int NUM_FWD   = 2;
  localparam int MAX_OUTST = 4;
  localparam int CNT_W     = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD),
    .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)
  ) bus ();

  hazard_scoreboard_unit #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD),
    .MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int exp_stall = 0;  // stalled cycles expected so far

  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.id_rd = '0; bus.id_we = 1'b0; bus.id_long = 1'b0; bus.id_valid = 1'b0;
    bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rs1_used = 1'b0; bus.ex_rs2_used = 1'b0;
    bus.ex_is_store = 1'b0; bus.stg_rd = '0; bus.stg_we = '0; bus.stg_rdy = '0;
    bus.lu_wb_valid = 1'b0; bus.lu_wb_rd = '0; bus.flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic long_issue(input logic [ADDR_W-1:0] rd);
    bus.id_valid = 1'b1; bus.id_long = 1'b1; bus.id_we = 1'b1; bus.id_rd = rd;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (bus.pending !== '0)      begin n_fail++; $display("FAIL reset_pending: got %h want 0", bus.pending); end
    n_checks++; if (bus.outst_cnt !== '0)    begin n_fail++; $display("FAIL reset_outst: got %0d want 0", bus.outst_cnt); end
    n_checks++; if (bus.stall_cycles !== '0) begin n_fail++; $display("FAIL reset_stall_cycles: got %0d want 0", bus.stall_cycles); end
    n_checks++; if (bus.stall !== 1'b0)      begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_checks++; if (bus.fwd_a !== 2'd0)      begin n_fail++; $display("FAIL reset_fwd_a: got %0d want 0", bus.fwd_a); end
  endtask

  task automatic test_fwd_priority();
    bus.stg_rd = {5'd5, 5'd5}; bus.stg_we = 2'b11; bus.stg_rdy = 2'b11;
    bus.ex_rs1 = 5'd5; bus.ex_rs1_used = 1'b1;
    #1;
    n_checks++; if (bus.fwd_a !== 2'd1) begin n_fail++; $display("FAIL fwd_youngest: got %0d want 1", bus.fwd_a); end
    bus.stg_rd = {5'd5, 5'd6};
    #1;
    n_checks++; if (bus.fwd_a !== 2'd2) begin n_fail++; $display("FAIL fwd_older: got %0d want 2", bus.fwd_a); end
    bus.stg_rd = {5'd5, 5'd5}; bus.stg_rdy = 2'b10;
    #1;
    n_checks++; if (bus.fwd_a !== 2'd0) begin n_fail++; $display("FAIL fwd_blocked: got %0d want 0", bus.fwd_a); end
    bus.stg_rdy = 2'b11; bus.ex_rs2 = 5'd5; bus.ex_rs2_used = 1'b0; bus.ex_is_store = 1'b1;
    #1;
    n_checks++; if (bus.fwd_b !== 2'd0)  begin n_fail++; $display("FAIL fwd_b_unused: got %0d want 0", bus.fwd_b); end
    n_checks++; if (bus.fwd_st !== 2'd1) begin n_fail++; $display("FAIL fwd_st_young: got %0d want 1", bus.fwd_st); end
    bus.stg_we = 2'b10;
    @(negedge clk);
    n_checks++; if (bus.fwd_st !== 2'd2) begin n_fail++; $display("FAIL fwd_st_old: got %0d want 2", bus.fwd_st); end
    idle();
  endtask

  task automatic test_x0();
    @(negedge clk);
    bus.stg_rd = '0; bus.stg_we = 2'b01; bus.stg_rdy = 2'b00;
    bus.ex_rs1 = '0; bus.ex_rs1_used = 1'b1; bus.ex_rs2 = '0; bus.ex_rs2_used = 1'b1;
    bus.id_valid = 1'b1; bus.id_rs1 = '0; bus.id_rs1_used = 1'b1; bus.id_rs2 = '0; bus.id_rs2_used = 1'b1;
    #1;
    n_checks++; if (bus.fwd_a !== 2'd0) begin n_fail++; $display("FAIL x0_fwd_a: got %0d want 0", bus.fwd_a); end
    n_checks++; if (bus.fwd_b !== 2'd0) begin n_fail++; $display("FAIL x0_fwd_b: got %0d want 0", bus.fwd_b); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall: got %b want 0", bus.stall); end
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    bus.stg_rd = {5'd0, 5'd7}; bus.stg_we = 2'b01; bus.stg_rdy = 2'b00;
    bus.id_valid = 1'b1; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
    step(); exp_stall++;
    n_checks++; if (bus.stall_cycles !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL lu_cycles: got %0d want %0d", bus.stall_cycles, exp_stall); end
    bus.stg_rdy = 2'b01;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_release: got %b want 0", bus.stall); end
    bus.id_valid = 1'b0; bus.id_rs2_used = 1'b0; bus.ex_rs2 = 5'd7; bus.ex_rs2_used = 1'b1;
    #1;
    n_checks++; if (bus.fwd_b !== 2'd1) begin n_fail++; $display("FAIL lu_fwd_b: got %0d want 1", bus.fwd_b); end
    idle();
  endtask

  task automatic test_long_raw_waw();
    @(negedge clk);
    long_issue(5'd9);
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL long_issue_stall: got %b want 0", bus.stall); end
    step(); idle();
    #1;
    n_checks++; if (bus.pending[9] !== 1'b1) begin n_fail++; $display("FAIL long_pending9: got %b want 1", bus.pending[9]); end
    n_checks++; if (bus.outst_cnt !== 3'd1) begin n_fail++; $display("FAIL long_outst1: got %0d want 1", bus.outst_cnt); end
    bus.id_valid = 1'b1; bus.id_we = 1'b1; bus.id_rd = 5'd10; bus.id_rs1 = 5'd9; bus.id_rs1_used = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", bus.stall); end
    step(); exp_stall++;
    bus.lu_wb_valid = 1'b1; bus.lu_wb_rd = 5'd9;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle: got %b want 1", bus.stall); end
    step(); exp_stall++;
    bus.lu_wb_valid = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL raw_after_wb: got %b want 0", bus.stall); end
    n_checks++; if (bus.outst_cnt !== 3'd0) begin n_fail++; $display("FAIL raw_outst0: got %0d want 0", bus.outst_cnt); end
    idle(); long_issue(5'd9);
    step(); idle();
    #1;
    bus.id_valid = 1'b1; bus.id_we = 1'b1; bus.id_rd = 5'd9;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b want 1", bus.stall); end
    bus.id_valid = 1'b0;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL waw_invalid: got %b want 0", bus.stall); end
    idle(); bus.lu_wb_valid = 1'b1; bus.lu_wb_rd = 5'd9;
    step(); idle();
    #1;
    n_checks++; if (bus.pending !== '0) begin n_fail++; $display("FAIL waw_clean: got %h want 0", bus.pending); end
    n_checks++; if (bus.stall_cycles !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL raw_cycles: got %0d want %0d", bus.stall_cycles, exp_stall); end
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      long_issue(ADDR_W'(r));
      @(posedge clk);
    end
    @(negedge clk); idle();
    #1;
    n_checks++; if (bus.outst_cnt !== 3'd4) begin n_fail++; $display("FAIL cap_outst4: got %0d want 4", bus.outst_cnt); end
    n_checks++; if (bus.pending !== 32'h0000_001E) begin n_fail++; $display("FAIL cap_pending: got %h want 0000001e", bus.pending); end
    long_issue(5'd5);
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL cap_fifth: got %b want 1", bus.stall); end
    // Re-issue of rd=1 alongside its writeback: WAW and capacity block it.
    long_issue(5'd1); bus.lu_wb_valid = 1'b1; bus.lu_wb_rd = 5'd1;
    step(); exp_stall++; idle();
    #1;
    n_checks++; if (bus.pending !== 32'h0000_001C) begin n_fail++; $display("FAIL sim_blocked_pending: got %h want 0000001c", bus.pending); end
    n_checks++; if (bus.outst_cnt !== 3'd3) begin n_fail++; $display("FAIL sim_blocked_outst: got %0d want 3", bus.outst_cnt); end
    long_issue(5'd5); bus.lu_wb_valid = 1'b1; bus.lu_wb_rd = 5'd2;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL sim_issue_stall: got %b want 0", bus.stall); end
    step(); idle();
    #1;
    n_checks++; if (bus.pending !== 32'h0000_0038) begin n_fail++; $display("FAIL sim_pending: got %h want 00000038", bus.pending); end
    n_checks++; if (bus.outst_cnt !== 3'd3) begin n_fail++; $display("FAIL sim_outst: got %0d want 3", bus.outst_cnt); end
    bus.lu_wb_valid = 1'b1; bus.lu_wb_rd = 5'd2;
    step(); idle();
    #1;
    n_checks++; if (bus.outst_cnt !== 3'd3) begin n_fail++; $display("FAIL stray_wb_outst: got %0d want 3", bus.outst_cnt); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    long_issue(5'd6); bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
    step(); idle();
    #1;
    n_checks++; if (bus.pending !== 32'h0000_0038) begin n_fail++; $display("FAIL flush_pending: got %h want 00000038", bus.pending); end
    n_checks++; if (bus.outst_cnt !== 3'd3) begin n_fail++; $display("FAIL flush_outst: got %0d want 3", bus.outst_cnt); end
    n_checks++; if (bus.stall_cycles !== CNT_W'(exp_stall)) begin n_fail++; $display("FAIL flush_cycles: got %0d want %0d", bus.stall_cycles, exp_stall); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.stg_rd = {5'd0, 5'd7}; bus.stg_we = 2'b01; bus.stg_rdy = 2'b00;
    bus.id_valid = 1'b1; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
    #1;
    n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL pre_rst_stall: got %b want 1", bus.stall); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.pending !== '0)      begin n_fail++; $display("FAIL rst_pending: got %h want 0", bus.pending); end
    n_checks++; if (bus.outst_cnt !== '0)    begin n_fail++; $display("FAIL rst_outst: got %0d want 0", bus.outst_cnt); end
    n_checks++; if (bus.stall_cycles !== '0) begin n_fail++; $display("FAIL rst_cycles: got %0d want 0", bus.stall_cycles); end
    n_checks++; if (bus.stall !== 1'b0)      begin n_fail++; $display("FAIL rst_stall_forced: got %b want 0", bus.stall); end
    idle();
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++; if (bus.outst_cnt !== '0) begin n_fail++; $display("FAIL post_rst_outst: got %0d want 0", bus.outst_cnt); end
  endtask

  initial begin
    idle();
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_fwd_priority();
    test_x0();
    test_load_use();
    test_long_raw_waw();
    test_capacity();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
